// File: rtl/timer_apb_regs.sv
// APB register slave for an 8-bit timer: TDR reload value, TCR control bits,
// sticky TSR flags and a read-only view of the live counter value.
module timer_apb_regs #(
  parameter int WAIT = 1
) (
  input  logic       pclk,
  input  logic       presetn,
  input  logic       psel,
  input  logic       penable,
  input  logic       pwrite,
  input  logic [7:0] paddr,
  input  logic [7:0] pwdata,
  output logic [7:0] prdata,
  output logic       pready,
  output logic       pslverr,
  output logic [7:0] tdr_o,
  output logic       load_o,
  output logic       dw_o,
  output logic       en_o,
  output logic [1:0] cks_o,
  input  logic       ovf_i,
  input  logic       udf_i,
  input  logic [7:0] cnt_i,
  output logic [1:0] state_o
);

  // APB handshake: a transfer completes on the rising edge where psel, penable
  // and pready are all high; pready is high only while the FSM is in ACCESS.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_ACCESS = 2'd3;

  localparam logic [7:0] TCR_MASK = 8'hB3;

  logic [1:0] state_q, state_d;
  logic [7:0] tdr_q, tdr_d;
  logic [7:0] tcr_q, tcr_d;
  logic [1:0] tsr_q, tsr_d;

  logic       xfer;
  logic       addr_err;
  logic       wr_en;
  logic [1:0] tsr_keep;
  logic [7:0] rdata;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (psel && !penable) state_d = ST_SETUP;
      ST_SETUP: begin
        if (!psel)          state_d = ST_IDLE;
        else if (WAIT != 0) state_d = ST_WAIT;
        else                state_d = ST_ACCESS;
      end
      // Losing psel while stalled abandons the transfer.
      ST_WAIT:   state_d = psel ? ST_ACCESS : ST_IDLE;
      ST_ACCESS: state_d = (psel && !penable) ? ST_SETUP : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign xfer     = (state_q == ST_ACCESS) && psel && penable;
  assign addr_err = (paddr > 8'd3) || (pwrite && (paddr == 8'd3));
  assign wr_en    = xfer && pwrite && !addr_err;

  always_comb begin
    rdata = 8'h00;
    case (paddr)
      8'd0:    rdata = tdr_q;
      8'd1:    rdata = tcr_q;
      8'd2:    rdata = {6'b0, tsr_q};
      8'd3:    rdata = cnt_i;
      default: rdata = 8'h00;
    endcase
  end

  // Writing 0 clears a flag; a same-cycle hardware pulse still sets it.
  assign tsr_keep = (wr_en && (paddr == 8'd2)) ? pwdata[1:0] : 2'b11;

  always_comb begin
    tdr_d = tdr_q;
    tcr_d = tcr_q;
    tsr_d = (tsr_q & tsr_keep) | {udf_i, ovf_i};
    if (wr_en && (paddr == 8'd0)) tdr_d = pwdata;
    if (wr_en && (paddr == 8'd1)) tcr_d = pwdata & TCR_MASK;
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= ST_IDLE;
      tdr_q   <= 8'h00;
      tcr_q   <= 8'h00;
      tsr_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      tdr_q   <= tdr_d;
      tcr_q   <= tcr_d;
      tsr_q   <= tsr_d;
    end
  end

  assign pready  = (state_q == ST_ACCESS);
  assign pslverr = xfer && addr_err;
  assign prdata  = (xfer && !pwrite && !addr_err) ? rdata : 8'h00;

  assign tdr_o   = tdr_q;
  assign load_o  = tcr_q[7];
  assign dw_o    = tcr_q[5];
  assign en_o    = tcr_q[4];
  assign cks_o   = tcr_q[1:0];
  assign state_o = state_q;

endmodule
